keypad_scanner_4x4: RTL

- Scans a 4x4 matrix keypad and debounces the key presses.
- Emits a 4-bit key code plus a one-cycle valid strobe.
- Sits directly upstream of the 4-to-16 one-hot decoder: key_code feeds the decoder input, and its 16-bit output lights one LED per key.
- Synchronous FSM with a column-dwell prescaler, a 2-flop row synchronizer and press/release debounce counters.

---
 rtl/keypad_pkg.sv | 25 ++
 rtl/tick_gen.sv | 25 ++
 rtl/keypad_scanner_4x4.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared state encoding, constants and row helper for the keypad scanner
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    DEBOUNCE_P = 2'd1,
    HELD       = 2'd2,
    DEBOUNCE_R = 2'd3
  } state_t;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam logic [ROWS-1:0] ROWS_IDLE = 4'hF;

  // Index of the lowest row pulled low; only meaningful when rows != ROWS_IDLE.
  function automatic logic [1:0] lowest_zero(input logic [ROWS-1:0] rows);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = ROWS - 1; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - free-running prescaler emitting a one-cycle tick every DIV clocks
module tick_gen #(
  parameter int DIV = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int W = $clog2(DIV);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == W'(DIV - 1));

  always_comb begin
    cnt_d = tick_o ? '0 : cnt_q + W'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/keypad_scanner_4x4.sv
// rtl/keypad_scanner_4x4.sv - 4x4 keypad column scanner with press/release debounce
// Optional auto-repeat while held: define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner_4x4
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_TICKS = 4
`ifdef KEYPAD_AUTOREPEAT_EN
  , parameter int REPEAT_TICKS = 250
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [ROWS-1:0] row_in,
  output logic [COLS-1:0] col_out,
  output logic [3:0]      key_code,
  output logic            key_valid,
  output logic            key_held
);

  localparam int DW = $clog2(DEBOUNCE_TICKS + 1);

  logic            tick;
  logic [ROWS-1:0] sync1_q, rows_s;
  state_t          state_q, state_d;
  logic [1:0]      col_q, col_d;
  logic [1:0]      cand_row_q, cand_row_d;
  logic [1:0]      cand_col_q, cand_col_d;
  logic [DW-1:0]   deb_cnt_q, deb_cnt_d, deb_inc;
  logic [3:0]      key_code_q, key_code_d;
  logic            key_valid_q, key_valid_d;
  logic            key_held_q, key_held_d;
  logic            row_low, acc_fire, rel_fire;

`ifdef KEYPAD_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_TICKS + 1);
  logic [RW-1:0] rep_cnt_q, rep_cnt_d, rep_inc;
`endif

  tick_gen #(.DIV(SCAN_DIV)) u_tick_gen (
    .clk_i  (clk),
    .rst_i  (rst),
    .tick_o (tick)
  );

  assign col_out   = ~(COLS'(1) << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = key_held_q;

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    cand_row_d  = cand_row_q;
    cand_col_d  = cand_col_q;
    deb_cnt_d   = deb_cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
    acc_fire    = 1'b0;
    rel_fire    = 1'b0;
    row_low     = ~rows_s[cand_row_q];
    deb_inc     = deb_cnt_q + DW'(1);
`ifdef KEYPAD_AUTOREPEAT_EN
    rep_cnt_d   = rep_cnt_q;
    rep_inc     = rep_cnt_q + RW'(1);
`endif
    if (tick) begin
      unique case (state_q)
        SCAN: begin
          if (rows_s == ROWS_IDLE) begin
            col_d = col_q + 2'd1;
          end else begin
            cand_row_d = lowest_zero(rows_s);
            cand_col_d = col_q;
            deb_cnt_d  = DW'(1);
            if (DEBOUNCE_TICKS == 1) acc_fire = 1'b1;
            else                     state_d  = DEBOUNCE_P;
          end
        end
        DEBOUNCE_P: begin
          if (row_low) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DW'(DEBOUNCE_TICKS)) acc_fire = 1'b1;
          end else begin
            state_d = SCAN;
            col_d   = col_q + 2'd1;
          end
        end
        HELD: begin
          if (!row_low) begin
            deb_cnt_d = DW'(1);
            if (DEBOUNCE_TICKS == 1) rel_fire = 1'b1;
            else                     state_d  = DEBOUNCE_R;
          end
`ifdef KEYPAD_AUTOREPEAT_EN
          else if (rep_inc == RW'(REPEAT_TICKS)) begin
            rep_cnt_d   = '0;
            key_valid_d = 1'b1;
          end else begin
            rep_cnt_d = rep_inc;
          end
`endif
        end
        DEBOUNCE_R: begin
          if (!row_low) begin
            deb_cnt_d = deb_inc;
            if (deb_inc == DW'(DEBOUNCE_TICKS)) rel_fire = 1'b1;
          end else begin
            state_d = HELD;
          end
        end
      endcase
    end
    if (acc_fire) begin
      state_d     = HELD;
      key_code_d  = {cand_row_d, cand_col_d};
      key_valid_d = 1'b1;
      key_held_d  = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
      rep_cnt_d   = '0;
`endif
    end
    if (rel_fire) begin
      state_d    = SCAN;
      key_held_d = 1'b0;
      col_d      = col_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= ROWS_IDLE;
      rows_s      <= ROWS_IDLE;
      state_q     <= SCAN;
      col_q       <= 2'd0;
      cand_row_q  <= 2'd0;
      cand_col_q  <= 2'd0;
      deb_cnt_q   <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      sync1_q     <= row_in;
      rows_s      <= sync1_q;
      state_q     <= state_d;
      col_q       <= col_d;
      cand_row_q  <= cand_row_d;
      cand_col_q  <= cand_col_d;
      deb_cnt_q   <= deb_cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

`ifdef KEYPAD_AUTOREPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rep_cnt_q <= '0;
    else     rep_cnt_q <= rep_cnt_d;
  end
`endif

endmodule
